// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS EX stage: opcodes, functs, ALU classes,
// forwarding/B-source selects and the internal ALU operation enum.
package mips_pkg;

  localparam int unsigned NB_OPCODE = 6;
  localparam int unsigned NB_FUNC   = 6;
  localparam int unsigned NB_SHAMT  = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] FWD_ID  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [1:0] ALUSRC_RT   = 2'b00;
  localparam logic [1:0] ALUSRC_IMM  = 2'b01;
  localparam logic [1:0] ALUSRC_ZIMM = 2'b10;

  localparam logic [NB_FUNC-1:0] FN_SLL  = 6'b000000;
  localparam logic [NB_FUNC-1:0] FN_SRL  = 6'b000010;
  localparam logic [NB_FUNC-1:0] FN_SRA  = 6'b000011;
  localparam logic [NB_FUNC-1:0] FN_SLLV = 6'b000100;
  localparam logic [NB_FUNC-1:0] FN_SRLV = 6'b000110;
  localparam logic [NB_FUNC-1:0] FN_SRAV = 6'b000111;
  localparam logic [NB_FUNC-1:0] FN_ADD  = 6'b100000;
  localparam logic [NB_FUNC-1:0] FN_ADDU = 6'b100001;
  localparam logic [NB_FUNC-1:0] FN_SUB  = 6'b100010;
  localparam logic [NB_FUNC-1:0] FN_SUBU = 6'b100011;
  localparam logic [NB_FUNC-1:0] FN_AND  = 6'b100100;
  localparam logic [NB_FUNC-1:0] FN_OR   = 6'b100101;
  localparam logic [NB_FUNC-1:0] FN_XOR  = 6'b100110;
  localparam logic [NB_FUNC-1:0] FN_NOR  = 6'b100111;
  localparam logic [NB_FUNC-1:0] FN_SLT  = 6'b101010;

  localparam logic [NB_OPCODE-1:0] OP_ADDI  = 6'b001000;
  localparam logic [NB_OPCODE-1:0] OP_ADDIU = 6'b001001;
  localparam logic [NB_OPCODE-1:0] OP_SLTI  = 6'b001010;
  localparam logic [NB_OPCODE-1:0] OP_ANDI  = 6'b001100;
  localparam logic [NB_OPCODE-1:0] OP_ORI   = 6'b001101;
  localparam logic [NB_OPCODE-1:0] OP_XORI  = 6'b001110;
  localparam logic [NB_OPCODE-1:0] OP_LUI   = 6'b001111;

  typedef enum logic [3:0] {
    ALU_ZERO, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

endpackage

// File: rtl/instruction_execute_alu.sv
// Combinational ALU for the EX stage. Signed add/sub overflow is only
// reported when EX_OVERFLOW_TRAP_EN is defined; otherwise it is tied low.
module alu
  import mips_pkg::*;
#(
  parameter int unsigned NB_DATA = 32
) (
  input  alu_op_e              op_i,
  input  logic [NB_DATA-1:0]   a_i,
  input  logic [NB_DATA-1:0]   b_i,
  input  logic [NB_SHAMT-1:0]  shamt_i,
  output logic [NB_DATA-1:0]   result_c_o,
  output logic                 overflow_c_o
);

  logic [NB_DATA-1:0] sum;
  logic [NB_DATA-1:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  always_comb begin
    result_c_o = '0;
    case (op_i)
      ALU_ADD: result_c_o = sum;
      ALU_SUB: result_c_o = diff;
      ALU_AND: result_c_o = a_i & b_i;
      ALU_OR:  result_c_o = a_i | b_i;
      ALU_XOR: result_c_o = a_i ^ b_i;
      ALU_NOR: result_c_o = ~(a_i | b_i);
      ALU_SLT: result_c_o = NB_DATA'($signed(a_i) < $signed(b_i));
      ALU_SLL: result_c_o = b_i << shamt_i;
      ALU_SRL: result_c_o = b_i >> shamt_i;
      ALU_SRA: result_c_o = NB_DATA'($signed(b_i) >>> shamt_i);
      ALU_LUI: result_c_o = NB_DATA'(b_i[15:0]) << 16;
      default: result_c_o = '0;
    endcase
  end

`ifdef EX_OVERFLOW_TRAP_EN
  // Two's-complement overflow: operand signs vs. result sign.
  always_comb begin
    overflow_c_o = 1'b0;
    if (op_i == ALU_ADD)
      overflow_c_o = (a_i[NB_DATA-1] == b_i[NB_DATA-1]) && (sum[NB_DATA-1] != a_i[NB_DATA-1]);
    else if (op_i == ALU_SUB)
      overflow_c_o = (a_i[NB_DATA-1] != b_i[NB_DATA-1]) && (diff[NB_DATA-1] != a_i[NB_DATA-1]);
  end
`else
  assign overflow_c_o = 1'b0;
`endif

endmodule

// File: rtl/instruction_execute.sv
// MIPS EX stage: forwarding, B-operand select, ALU control and the EX/MEM
// register. Overflow trapping is enabled by defining EX_OVERFLOW_TRAP_EN.
module instruction_execute
  import mips_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_halt,
  input  logic                 i_flush,
  input  logic [NB_DATA-1:0]   i_reg_DA,
  input  logic [NB_DATA-1:0]   i_reg_DB,
  input  logic [NB_DATA-1:0]   i_immediate,
  input  logic [5:0]           i_opcode,
  input  logic [5:0]           i_func,
  input  logic [4:0]           i_shamt,
  input  logic [NB_REG-1:0]    i_rt,
  input  logic [NB_REG-1:0]    i_rd,
  input  logic                 i_regDst,
  input  logic                 i_mem2Reg,
  input  logic                 i_memRead,
  input  logic                 i_memWrite,
  input  logic                 i_regWrite,
  input  logic [1:0]           i_aluSrc,
  input  logic [1:0]           i_aluOp,
  input  logic [1:0]           i_fwd_a,
  input  logic [1:0]           i_fwd_b,
  input  logic [NB_DATA-1:0]   i_fwd_data_M,
  input  logic [NB_DATA-1:0]   i_fwd_data_WB,
  output logic [NB_DATA-1:0]   o_alu_result,
  output logic [NB_DATA-1:0]   o_data4mem,
  output logic [NB_REG-1:0]    o_write_reg,
  output logic                 o_mem2Reg,
  output logic                 o_memRead,
  output logic                 o_memWrite,
  output logic                 o_regWrite,
  output logic                 o_overflow
);

  logic [NB_DATA-1:0]  opa, rtv, bsel, alu_b, alu_res;
  logic [NB_SHAMT-1:0] shamt;
  alu_op_e             alu_op;
  logic                use_rtv, chk_ovf, alu_ovf;

  logic [NB_DATA-1:0]  alu_result_d, alu_result_q, data4mem_d, data4mem_q;
  logic [NB_REG-1:0]   write_reg_d, write_reg_q;
  logic                mem2reg_d, mem2reg_q, memread_d, memread_q;
  logic                memwrite_d, memwrite_q, regwrite_d, regwrite_q;
  logic                overflow_d, overflow_q;

  // Forwarding select; the unused code 11 falls back to the ID value.
  always_comb begin
    opa = i_reg_DA;
    if (i_fwd_a == FWD_MEM)     opa = i_fwd_data_M;
    else if (i_fwd_a == FWD_WB) opa = i_fwd_data_WB;
    rtv = i_reg_DB;
    if (i_fwd_b == FWD_MEM)     rtv = i_fwd_data_M;
    else if (i_fwd_b == FWD_WB) rtv = i_fwd_data_WB;
    bsel = rtv;
    if (i_aluSrc == ALUSRC_IMM)       bsel = i_immediate;
    else if (i_aluSrc == ALUSRC_ZIMM) bsel = NB_DATA'(i_immediate[15:0]);
  end

  // ALU control; chk_ovf marks the signed forms that may trap.
  always_comb begin
    alu_op  = ALU_ZERO;
    shamt   = i_shamt;
    use_rtv = 1'b0;
    chk_ovf = 1'b0;
    case (i_aluOp)
      ALUOP_ADD: alu_op = ALU_ADD;
      ALUOP_SUB: alu_op = ALU_SUB;
      ALUOP_RTYPE: begin
        case (i_func)
          FN_ADD:  begin alu_op = ALU_ADD; chk_ovf = 1'b1; end
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUB:  begin alu_op = ALU_SUB; chk_ovf = 1'b1; end
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  begin alu_op = ALU_SLL; use_rtv = 1'b1; end
          FN_SRL:  begin alu_op = ALU_SRL; use_rtv = 1'b1; end
          FN_SRA:  begin alu_op = ALU_SRA; use_rtv = 1'b1; end
          FN_SLLV: begin alu_op = ALU_SLL; use_rtv = 1'b1; shamt = opa[4:0]; end
          FN_SRLV: begin alu_op = ALU_SRL; use_rtv = 1'b1; shamt = opa[4:0]; end
          FN_SRAV: begin alu_op = ALU_SRA; use_rtv = 1'b1; shamt = opa[4:0]; end
          default: alu_op = ALU_ZERO;
        endcase
      end
      ALUOP_ITYPE: begin
        case (i_opcode)
          OP_ADDI:  begin alu_op = ALU_ADD; chk_ovf = 1'b1; end
          OP_ADDIU: alu_op = ALU_ADD;
          OP_ANDI:  alu_op = ALU_AND;
          OP_ORI:   alu_op = ALU_OR;
          OP_XORI:  alu_op = ALU_XOR;
          OP_SLTI:  alu_op = ALU_SLT;
          OP_LUI:   alu_op = ALU_LUI;
          default:  alu_op = ALU_ZERO;
        endcase
      end
      default: alu_op = ALU_ZERO;
    endcase
    alu_b = use_rtv ? rtv : bsel;
  end

  alu #(.NB_DATA(NB_DATA)) u_alu (
    .op_i         (alu_op),
    .a_i          (opa),
    .b_i          (alu_b),
    .shamt_i      (shamt),
    .result_c_o   (alu_res),
    .overflow_c_o (alu_ovf)
  );

  // EX/MEM next state: normal load unless a bubble is requested.
  always_comb begin
    alu_result_d = alu_res;
    data4mem_d   = rtv;
    write_reg_d  = i_regDst ? i_rd : i_rt;
    mem2reg_d    = i_mem2Reg;
    memread_d    = i_memRead;
    memwrite_d   = i_memWrite;
    overflow_d   = alu_ovf & chk_ovf;
    regwrite_d   = i_regWrite & ~overflow_d;
    if (i_flush) begin
      alu_result_d = '0;
      data4mem_d   = '0;
      write_reg_d  = '0;
      mem2reg_d    = 1'b0;
      memread_d    = 1'b0;
      memwrite_d   = 1'b0;
      overflow_d   = 1'b0;
      regwrite_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alu_result_q <= '0;
      data4mem_q   <= '0;
      write_reg_q  <= '0;
      mem2reg_q    <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (!i_halt) begin
      alu_result_q <= alu_result_d;
      data4mem_q   <= data4mem_d;
      write_reg_q  <= write_reg_d;
      mem2reg_q    <= mem2reg_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      regwrite_q   <= regwrite_d;
      overflow_q   <= overflow_d;
    end
  end

  assign o_alu_result = alu_result_q;
  assign o_data4mem   = data4mem_q;
  assign o_write_reg  = write_reg_q;
  assign o_mem2Reg    = mem2reg_q;
  assign o_memRead    = memread_q;
  assign o_memWrite   = memwrite_q;
  assign o_regWrite   = regwrite_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_instruction_execute.sv
// Scoreboard bench for instruction_execute: the driver pushes reference-model
// expectations, a monitor pops and compares after every rising edge.
module tb_instruction_execute;

  logic        clk = 1'b0;
  logic        i_rst_n, i_halt, i_flush;
  logic [31:0] i_reg_DA, i_reg_DB, i_immediate, i_fwd_data_M, i_fwd_data_WB;
  logic [5:0]  i_opcode, i_func;
  logic [4:0]  i_shamt, i_rt, i_rd;
  logic        i_regDst, i_mem2Reg, i_memRead, i_memWrite, i_regWrite;
  logic [1:0]  i_aluSrc, i_aluOp, i_fwd_a, i_fwd_b;
  logic [31:0] o_alu_result, o_data4mem;
  logic [4:0]  o_write_reg;
  logic        o_mem2Reg, o_memRead, o_memWrite, o_regWrite, o_overflow;

`ifdef EX_OVERFLOW_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] da, db, imm, fm, fwb;
    logic [5:0]  opcode, func;
    logic [4:0]  shamt, rt, rd;
    logic        regDst, m2r, mr, mw, rw, halt, flush;
    logic [1:0]  aluSrc, aluOp, fa, fb;
  } stim_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] d4m;
    logic [4:0]  wr;
    logic        m2r, mr, mw, rw, ovf;
  } exp_t;

  exp_t q[$];
  exp_t last;
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic [5:0] fn_list[15];
  logic [5:0] op_list[7];

  instruction_execute dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_halt(i_halt), .i_flush(i_flush),
    .i_reg_DA(i_reg_DA), .i_reg_DB(i_reg_DB), .i_immediate(i_immediate),
    .i_opcode(i_opcode), .i_func(i_func), .i_shamt(i_shamt),
    .i_rt(i_rt), .i_rd(i_rd), .i_regDst(i_regDst), .i_mem2Reg(i_mem2Reg),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_regWrite(i_regWrite),
    .i_aluSrc(i_aluSrc), .i_aluOp(i_aluOp), .i_fwd_a(i_fwd_a), .i_fwd_b(i_fwd_b),
    .i_fwd_data_M(i_fwd_data_M), .i_fwd_data_WB(i_fwd_data_WB),
    .o_alu_result(o_alu_result), .o_data4mem(o_data4mem), .o_write_reg(o_write_reg),
    .o_mem2Reg(o_mem2Reg), .o_memRead(o_memRead), .o_memWrite(o_memWrite),
    .o_regWrite(o_regWrite), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pick(logic [1:0] s, logic [31:0] idv, logic [31:0] m, logic [31:0] wb);
    if (s == 2'd1) return m;
    if (s == 2'd2) return wb;
    return idv;
  endfunction

  // Reference model: plain arithmetic, overflow detected via 64-bit signed range.
  function automatic exp_t model(stim_t s);
    exp_t e;
    logic [31:0] a, rtv, b, r;
    logic signed [31:0] sa, sb;
    longint wide;
    bit sgn, ovf;
    a   = pick(s.fa, s.da, s.fm, s.fwb);
    rtv = pick(s.fb, s.db, s.fm, s.fwb);
    b   = (s.aluSrc == 2'd1) ? s.imm : (s.aluSrc == 2'd2) ? {16'h0, s.imm[15:0]} : rtv;
    sa = a; sb = b;
    r = 32'h0; sgn = 1'b0; wide = 0;
    case (s.aluOp)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: case (s.func)
        6'h20: begin r = a + b; sgn = 1'b1; wide = longint'(sa) + longint'(sb); end
        6'h21: r = a + b;
        6'h22: begin r = a - b; sgn = 1'b1; wide = longint'(sa) - longint'(sb); end
        6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2a: r = (sa < sb) ? 32'd1 : 32'd0;
        6'h00: r = rtv << s.shamt;
        6'h02: r = rtv >> s.shamt;
        6'h03: r = 32'($signed(rtv) >>> s.shamt);
        6'h04: r = rtv << a[4:0];
        6'h06: r = rtv >> a[4:0];
        6'h07: r = 32'($signed(rtv) >>> a[4:0]);
        default: r = 32'h0;
      endcase
      default: case (s.opcode)
        6'h08: begin r = a + b; sgn = 1'b1; wide = longint'(sa) + longint'(sb); end
        6'h09: r = a + b;
        6'h0c: r = a & b;
        6'h0d: r = a | b;
        6'h0e: r = a ^ b;
        6'h0a: r = (sa < sb) ? 32'd1 : 32'd0;
        6'h0f: r = {b[15:0], 16'h0};
        default: r = 32'h0;
      endcase
    endcase
    ovf = sgn && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
    e.alu = r; e.d4m = rtv; e.wr = s.regDst ? s.rd : s.rt;
    e.m2r = s.m2r; e.mr = s.mr; e.mw = s.mw;
    e.ovf = TRAP & ovf;
    e.rw  = s.rw & ~(TRAP & ovf);
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t a;
    a.alu = o_alu_result; a.d4m = o_data4mem; a.wr = o_write_reg;
    a.m2r = o_mem2Reg; a.mr = o_memRead; a.mw = o_memWrite;
    a.rw = o_regWrite; a.ovf = o_overflow;
    return a;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got alu=%h d4m=%h wr=%0d m2r%b mr%b mw%b rw%b ov%b, want alu=%h d4m=%h wr=%0d m2r%b mr%b mw%b rw%b ov%b",
               name, $time, act.alu, act.d4m, act.wr, act.m2r, act.mr, act.mw, act.rw, act.ovf,
               exp.alu, exp.d4m, exp.wr, exp.m2r, exp.mr, exp.mw, exp.rw, exp.ovf);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s.da = 0; s.db = 0; s.imm = 0; s.fm = 0; s.fwb = 0;
    s.opcode = 0; s.func = 6'h3f; s.shamt = 0; s.rt = 0; s.rd = 0;
    s.regDst = 0; s.m2r = 0; s.mr = 0; s.mw = 0; s.rw = 0; s.halt = 0; s.flush = 0;
    s.aluSrc = 0; s.aluOp = 2'd2; s.fa = 0; s.fb = 0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.da = $urandom; s.db = $urandom; s.imm = $urandom; s.fm = $urandom; s.fwb = $urandom;
    s.func   = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 14)];
    s.opcode = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_list[$urandom_range(0, 6)];
    s.shamt = 5'($urandom); s.rt = 5'($urandom); s.rd = 5'($urandom);
    s.regDst = 1'($urandom); s.m2r = 1'($urandom); s.mr = 1'($urandom);
    s.mw = 1'($urandom); s.rw = 1'($urandom);
    s.aluSrc = 2'($urandom); s.aluOp = 2'($urandom);
    s.fa = 2'($urandom); s.fb = 2'($urandom);
    s.halt  = ($urandom_range(0, 7) == 0);
    s.flush = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  // Drive one cycle at the falling edge and queue what the next rising edge must produce.
  task automatic cycle(input stim_t s, input bit rst);
    exp_t e;
    @(negedge clk);
    i_reg_DA = s.da; i_reg_DB = s.db; i_immediate = s.imm;
    i_fwd_data_M = s.fm; i_fwd_data_WB = s.fwb;
    i_opcode = s.opcode; i_func = s.func; i_shamt = s.shamt; i_rt = s.rt; i_rd = s.rd;
    i_regDst = s.regDst; i_mem2Reg = s.m2r; i_memRead = s.mr; i_memWrite = s.mw;
    i_regWrite = s.rw; i_aluSrc = s.aluSrc; i_aluOp = s.aluOp;
    i_fwd_a = s.fa; i_fwd_b = s.fb; i_halt = s.halt; i_flush = s.flush;
    i_rst_n = ~rst;
    if (rst)          e = '0;
    else if (s.halt)  e = last;
    else if (s.flush) e = '0;
    else              e = model(s);
    last = e;
    q.push_back(e);
    if (rst) begin
      #1;
      check("reset_async", dut_out(), exp_t'(0));
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      check("exmem", dut_out(), mon_e);
    end
  end

  initial begin
    stim_t s;
    fn_list = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2a, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    op_list = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0f};
    last = '0;
    s = nop();
    i_rst_n = 1'b0; i_halt = 0; i_flush = 0; i_reg_DA = 0; i_reg_DB = 0; i_immediate = 0;
    i_fwd_data_M = 0; i_fwd_data_WB = 0; i_opcode = 0; i_func = 0; i_shamt = 0;
    i_rt = 0; i_rd = 0; i_regDst = 0; i_mem2Reg = 0; i_memRead = 0; i_memWrite = 0;
    i_regWrite = 0; i_aluSrc = 0; i_aluOp = 0; i_fwd_a = 0; i_fwd_b = 0;
    #1 check("reset_state", dut_out(), exp_t'(0));
    cycle(s, 1'b1);
    cycle(s, 1'b1);

    s = nop(); s.func = 6'h20; s.da = 5; s.db = 7; s.regDst = 1; s.rd = 3; s.rw = 1;
    cycle(s, 1'b0);
    s = nop(); s.func = 6'h22; s.fa = 1; s.fm = 100; s.fb = 2; s.fwb = 1; s.da = 55; s.db = 66; s.rw = 1;
    cycle(s, 1'b0);
    s = nop(); s.aluOp = 0; s.aluSrc = 1; s.da = 32'h1000; s.imm = 32'hFFFFFFFC; s.db = 32'hAB; s.mw = 1;
    cycle(s, 1'b0);
    s = nop(); s.aluOp = 3; s.opcode = 6'h0d; s.aluSrc = 2; s.imm = 32'hFFFF8000; s.da = 1; s.rw = 1;
    cycle(s, 1'b0);
    s = nop(); s.aluOp = 3; s.opcode = 6'h0f; s.aluSrc = 1; s.imm = 32'h1234; s.rw = 1; s.rt = 9;
    cycle(s, 1'b0);
    for (int i = 0; i < 3; i++) begin
      s = rnd(); s.halt = 1; cycle(s, 1'b0);
    end
    s = rnd(); s.halt = 0; s.flush = 1; cycle(s, 1'b0);
    s = nop(); s.func = 6'h21; s.da = 9; s.db = 4; s.rw = 1; s.rd = 7; s.regDst = 1; cycle(s, 1'b0);
    s = rnd(); s.halt = 1; s.flush = 1; cycle(s, 1'b0);
    s = nop(); s.func = 6'h20; s.da = 32'h7FFFFFFF; s.db = 1; s.rw = 1; s.rd = 4; s.regDst = 1;
    cycle(s, 1'b0);
    s = nop(); s.func = 6'h22; s.da = 32'h80000000; s.db = 1; s.rw = 1; cycle(s, 1'b0);
    s = nop(); s.func = 6'h21; s.da = 32'h7FFFFFFF; s.db = 1; s.rw = 1; cycle(s, 1'b0);
    s = nop(); s.aluOp = 3; s.opcode = 6'h08; s.aluSrc = 1; s.da = 32'h80000000; s.imm = 32'hFFFFFFFF; s.rw = 1;
    cycle(s, 1'b0);
    // Mid-run reset with nonzero outputs, then a normal load right after release.
    s = nop(); s.func = 6'h25; s.da = 32'hF0; s.db = 32'h0F; s.rw = 1; s.mr = 1; s.rt = 2;
    cycle(s, 1'b0);
    cycle(rnd(), 1'b1);
    cycle(rnd(), 1'b1);
    s = rnd(); s.halt = 0; s.flush = 0; cycle(s, 1'b0);

    for (int i = 0; i < 600; i++) begin
      cycle(rnd(), ($urandom_range(0, 99) == 0));
    end
    s = nop();
    cycle(s, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
